column_carry_normalizer: RTL and testbench

//  Downstream of the 200-term column adder trees (sum200to1) in the modular-square datapath.

---
 rtl/column_carry_normalizer.sv | 132 +++++++++++++
 tb/tb_column_carry_normalizer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_carry_normalizer.sv
`timescale 1ns/1ps
// column_carry_normalizer
//
// Sits after the column adder trees of the modular-square datapath. It takes
// NUMCOLS wide column sums (column k weighs 2^(N*k)) and ripples the carries
// through them, COLS_PER_CYCLE columns per clock. The result is NUMCOLS
// normalized N-bit limbs plus the carry out of the top limb.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   col_in holds a valid set of column sums
//   in_ready   block accepts col_in on this edge (only while idle)
//   col_in     NUMCOLS column sums of N+8 bits, index 0 least significant
//   out_valid  limb_out / carry_out hold a finished result
//   out_ready  consumer takes the result on this edge
//   limb_out   NUMCOLS normalized N-bit limbs, index 0 least significant
//   carry_out  carry out of the top limb, never above 256
module column_carry_normalizer #(
   parameter int N              = 16,
   parameter int NUMCOLS        = 8,
   parameter int COLS_PER_CYCLE = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUMCOLS-1:0][N+7:0]     col_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUMCOLS-1:0][N-1:0]     limb_out,
   output logic [8:0]                    carry_out
);

   localparam int W  = N + 8;
   localparam int NG = NUMCOLS / COLS_PER_CYCLE;
   localparam int GW = (NG > 1) ? $clog2(NG) : 1;
   localparam int IW = (NUMCOLS > 1) ? $clog2(NUMCOLS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]                    state_q, state_d;
   logic [NUMCOLS-1:0][W-1:0]     col_q, col_d;
   logic [NUMCOLS-1:0][N-1:0]     limb_q, limb_d;
   logic [8:0]                    carry_q, carry_d;
   logic [8:0]                    carry_out_q, carry_out_d;
   logic [GW-1:0]                 grp_q, grp_d;

   logic [8:0]                    chain_c;
   logic [W:0]                    sum_t;
   logic [IW-1:0]                 col_idx;

   // Next-state logic. In RUN one group of columns is normalized per clock:
   // each column adds the carry coming out of the column below it, keeps the
   // low N bits as its limb and hands the rest upward. Since N >= 8 the
   // carry handed upward never exceeds 2^8, so a 9-bit carry is enough and
   // the W+1 bit adder cannot overflow.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      limb_d      = limb_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      grp_d       = grp_q;
      chain_c     = carry_q;
      sum_t       = '0;
      col_idx     = '0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               col_d   = col_in;
               carry_d = '0;
               grp_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            for (int i = 0; i < COLS_PER_CYCLE; i++) begin
               col_idx         = IW'(int'(grp_q) * COLS_PER_CYCLE + i);
               sum_t           = {1'b0, col_q[col_idx]} + {{N{1'b0}}, chain_c};
               limb_d[col_idx] = sum_t[N-1:0];
               chain_c         = sum_t[W:N];
            end
            carry_d = chain_c;
            if (grp_q == GW'(NG - 1)) begin
               carry_out_d = chain_c;
               state_d     = ST_DONE;
            end else begin
               grp_d = grp_q + GW'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State registers. Reset wipes everything, including any operand that
   // was half way through normalization.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         col_q       <= '0;
         limb_q      <= '0;
         carry_q     <= '0;
         carry_out_q <= '0;
         grp_q       <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         limb_q      <= limb_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         grp_q       <= grp_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign limb_out  = limb_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_column_carry_normalizer.sv
`timescale 1ns/1ps
// Testbench for column_carry_normalizer with N=16, NUMCOLS=8, COLS_PER_CYCLE=2.
// Directed operands with hand-computed limbs, handshake/latency/reset checks,
// then a randomized stream checked against the value-preservation invariant.
module tb_column_carry_normalizer;

   localparam int N       = 16;
   localparam int NUMCOLS = 8;
   localparam int CPC     = 2;
   localparam int W       = N + 8;

   typedef logic [NUMCOLS-1:0][W-1:0] cols_t;
   typedef logic [NUMCOLS-1:0][N-1:0] limbs_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   cols_t       col_in;
   logic        out_valid;
   logic        out_ready;
   limbs_t      limb_out;
   logic [8:0]  carry_out;

   int testsRun    = 0;
   int testsFailed = 0;

   column_carry_normalizer #(
      .N              (N),
      .NUMCOLS        (NUMCOLS),
      .COLS_PER_CYCLE (CPC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .col_in    (col_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .limb_out  (limb_out),
      .carry_out (carry_out)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a handshake never completes.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Numeric value of a column-sum operand.
   function automatic logic [159:0] colTotal(input cols_t c);
      logic [159:0] t;
      t = '0;
      for (int k = 0; k < NUMCOLS; k++) t = t + (160'(c[k]) << (N * k));
      return t;
   endfunction

   // Numeric value of a normalized result including the top carry.
   function automatic logic [159:0] limbTotal(input limbs_t l, input logic [8:0] c);
      logic [159:0] t;
      t = 160'(c) << (N * NUMCOLS);
      for (int k = 0; k < NUMCOLS; k++) t = t + (160'(l[k]) << (N * k));
      return t;
   endfunction

   // Present an operand and return 1 ns after the edge that accepted it.
   task automatic applyStimulus(input cols_t cols);
      int budget;
      budget = 0;
      @(negedge clk);
      col_in   = cols;
      in_valid = 1'b1;
      while (!in_ready && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 160'(in_ready), 160'(1));
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   // Wait (bounded) for out_valid at a falling edge and capture the result.
   task automatic waitResult(output limbs_t l, output logic [8:0] c);
      int budget;
      budget = 0;
      while (!out_valid && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("result_valid", 160'(out_valid), 160'(1));
      l = limb_out;
      c = carry_out;
   endtask

   // Accept the result on the next rising edge.
   task automatic releaseResult();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      cols_t        ops;
      limbs_t       lr;
      limbs_t       expL;
      logic [8:0]   cr;
      cols_t        pend;
      bit           havePend;
      int           sent;
      int           got;
      int           cycles;
      logic [159:0] sb[$];

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      col_in    = '0;

      // Reset state
      #2;
      checkOutput("rst_in_ready", 160'(in_ready), 160'(1));
      checkOutput("rst_out_valid", 160'(out_valid), 160'(0));
      checkOutput("rst_limbs", 160'(limb_out), 160'(0));
      checkOutput("rst_carry", 160'(carry_out), 160'(0));
      #10 rst_n = 1'b1;

      // Test 1: zero operand, latency of NG=4 edges after acceptance
      ops = '0;
      applyStimulus(ops);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t1_busy%0d", k), 160'(out_valid), 160'(0));
         checkOutput($sformatf("t1_inrdy%0d", k), 160'(in_ready), 160'(0));
      end
      @(negedge clk);
      checkOutput("t1_valid_after_4", 160'(out_valid), 160'(1));
      checkOutput("t1_limbs", 160'(limb_out), 160'(0));
      checkOutput("t1_carry", 160'(carry_out), 160'(0));
      releaseResult();

      // Test 2: every column at its maximum
      for (int k = 0; k < NUMCOLS; k++) ops[k] = 24'hFFFFFF;
      applyStimulus(ops);
      waitResult(lr, cr);
      expL = '0;
      expL[0] = 16'hFFFF;
      expL[1] = 16'h00FE;
      for (int k = 2; k < NUMCOLS; k++) expL[k] = 16'h00FF;
      for (int k = 0; k < NUMCOLS; k++)
         checkOutput($sformatf("t2_limb%0d", k), 160'(lr[k]), 160'(expL[k]));
      checkOutput("t2_carry", 160'(cr), 160'(9'h100));

      // Test 4: hold the result with out_ready low for 10 cycles
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t4_hold_limbs%0d", k), 160'(limb_out), 160'(expL));
         checkOutput($sformatf("t4_hold_carry%0d", k), 160'(carry_out), 160'(9'h100));
         checkOutput($sformatf("t4_hold_inrdy%0d", k), 160'(in_ready), 160'(0));
         checkOutput($sformatf("t4_hold_valid%0d", k), 160'(out_valid), 160'(1));
      end
      releaseResult();
      checkOutput("t4_idle_inrdy", 160'(in_ready), 160'(1));
      checkOutput("t4_idle_valid", 160'(out_valid), 160'(0));

      // Test 3: single carry out of column 0
      ops = '0;
      ops[0] = 24'h010000;
      applyStimulus(ops);
      waitResult(lr, cr);
      expL = '0;
      expL[1] = 16'h0001;
      checkOutput("t3_limbs", 160'(lr), 160'(expL));
      checkOutput("t3_carry", 160'(cr), 160'(0));
      releaseResult();

      // Test 5: reset pulse in the middle of RUN (grp=2)
      for (int k = 0; k < NUMCOLS; k++) ops[k] = 24'hFFFFFF;
      applyStimulus(ops);
      repeat (3) @(negedge clk);
      checkOutput("t5_running", 160'(out_valid), 160'(0));
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_valid", 160'(out_valid), 160'(0));
      checkOutput("t5_rst_inrdy", 160'(in_ready), 160'(1));
      checkOutput("t5_rst_limbs", 160'(limb_out), 160'(0));
      checkOutput("t5_rst_carry", 160'(carry_out), 160'(0));
      #2 rst_n = 1'b1;
      ops = '0;
      ops[0] = 24'h010000;
      applyStimulus(ops);
      waitResult(lr, cr);
      expL = '0;
      expL[1] = 16'h0001;
      checkOutput("t5_after_limbs", 160'(lr), 160'(expL));
      checkOutput("t5_after_carry", 160'(cr), 160'(0));
      releaseResult();

      // Test 6: random operands with random in_valid / out_ready.
      // Inputs change at the falling edge; handshakes are decided from the
      // registered in_ready/out_valid right after driving, for the next edge.
      havePend = 1'b0;
      sent     = 0;
      got      = 0;
      cycles   = 0;
      pend     = '0;
      while (got < 1000 && cycles < 60000) begin
         @(negedge clk);
         cycles++;
         if (!havePend && sent < 1000) begin
            for (int k = 0; k < NUMCOLS; k++) pend[k] = 24'($urandom_range(0, 32'h00FFFFFF));
            havePend = 1'b1;
         end
         col_in    = pend;
         in_valid  = havePend && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if (in_valid && in_ready) begin
            sb.push_back(colTotal(col_in));
            sent++;
            havePend = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checkOutput("t6_spurious_result", 160'(sb.size()), 160'(1));
            end else begin
               checkOutput($sformatf("t6_invariant%0d", got), limbTotal(limb_out, carry_out), sb.pop_front());
               checkOutput($sformatf("t6_carry_bound%0d", got), 160'(carry_out <= 9'd256), 160'(1));
            end
            got++;
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("t6_sent", 160'(sent), 160'(1000));
      checkOutput("t6_received", 160'(got), 160'(1000));
      checkOutput("t6_leftover", 160'(sb.size()), 160'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
